seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Parametrised N-digit multiplexed seven-segment scan controller; successor to the fixed 4-digit clock display driver.
- Runs from one system clock with internal refresh and blink dividers; no derived clocks.
- Adds per-digit blink mask, decimal points, hex decode, leading-zero blanking, and tear-free shadowed updates applied only at frame boundaries.
- Sits between timekeeping/counter logic and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; must be ≥2.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point enables, active-high.
- load  in  1  capture digits_in/dp_in into the shadow register.
- blink_mask  in  NUM_DIGITS  digits that blink; live, not shadowed.
- blank_lz  in  1  leading-zero blanking enable; live.
- anode_code  out  NUM_DIGITS  digit select, active-low, one-cold.
- seg_code  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- load_ack  out  1  one-cycle pulse when shadow data becomes active.
- frame_done  out  1  one-cycle pulse at end of the last digit slot.

Behaviour:
Reset values:
- Async assert. Outputs: anode_code = ~1 (digit 0 selected), seg_code = 7'b1111111, dp_n = 1, load_ack = 0, frame_done = 0.
- Internal state: refresh_cnt = 0, slot = 0, blink_cnt = 0, blink_phase = 0, active and shadow digits = 0, dps = 0, pend = 0.
- Reset mid-frame or mid-load discards all pending data.

Refresh:
- refresh_cnt counts 0..REFRESH_DIV-1 and wraps. Terminal count (tc) is refresh_cnt == REFRESH_DIV-1.
- On tc, slot advances, wrapping NUM_DIGITS-1 → 0.
- anode_code, seg_code and dp_n are all registered from the next slot value, so they change together on the same edge. No skew between anode and segments.

Blink:
- blink_cnt counts 0..BLINK_DIV-1. On its terminal count, blink_phase toggles.
- When blink_phase = 1 and blink_mask[next slot] = 1: seg_code = 7'b1111111 and dp_n = 1.
- Blink is independent of the refresh phase.

Decode:
- Hex, active-low. Examples: 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
- Digit-select widths are $clog2-sized. Counter widths are $clog2 of their divisor, minimum 1.

Leading-zero blanking:
- Applies when blank_lz = 1.
- Digit k (k ≥ 1) is blanked (segments only) if active digits k..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked by this rule. The dp is unaffected.

Load and shadow:
- On load = 1, the shadow register takes digits_in/dp_in and pend is set. Multiple loads before a boundary: last one wins.
- Frame boundary: tc with slot == NUM_DIGITS-1. At the boundary:
  - If pend = 1, active takes shadow, pend clears, and load_ack pulses on the following edge (registered).
  - If load = 1 in the boundary cycle itself, the incoming data bypasses to active, load_ack pulses, and pend ends 0.
- frame_done pulses one cycle on every boundary, registered alongside load_ack.
- The new data is first displayed in slot 0 of the next frame.

Degenerate case:
- NUM_DIGITS = 1: anode_code is constantly 0 after the first tc. Every tc is a frame boundary.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=64.
1. Reset, then load digits_in=16'h1234 once -> anode sequence 1110,1101,1011,0111 every 4 clks. After the first boundary, segs follow 4,3,2,1 (0011001,0110000,0100100,1111001). load_ack and frame_done pulse together once.
2. Tear-free update: load 16'hAAAA mid-frame at slot 1, then 16'h5555 at slot 2 -> remainder of frame unchanged. Next frame shows only 5 (0010010). Exactly one load_ack.
3. load asserted exactly on the boundary cycle with 16'h00F0 -> slot 0 of the next frame shows 0. Slot 1 shows F (0001110). load_ack pulses once and pend stays 0.
4. blank_lz=1 with active 16'h0070 -> digit 3 blank (1111111), digit 2 blank, digit 1 = 7 (1111000), digit 0 = 0. With 16'h0000 only digit 0 is lit.
5. blink_mask=4'b0011, dp_in=4'b0001 -> digits 0 and 1 plus dp_n toggle blank every 64 clks. Digits 2 and 3 stay steady.
6. Assert rst asynchronously mid-slot with pend=1 -> outputs reach reset values without a clk edge. After release there is no load_ack, and the display shows 0 in slot 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller: hex decode, per-digit blink,
// leading-zero blanking and shadowed data that only changes at frame boundaries.

module seg_hex_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg_n
);
  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg_n = 7'b1111111;
    case (nib)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      4'hF: seg_n = 7'b0001110;
      default: seg_n = 7'b1111111;
    endcase
    if (blank) seg_n = 7'b1111111;
  end
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   anode_code,
  output logic [6:0]              seg_code,
  output logic                    dp_n,
  output logic                    load_ack,
  output logic                    frame_done
);
  localparam int SLOT_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCNT_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;
  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [RCNT_W-1:0]     REF_LAST   = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [BCNT_W-1:0]     BLINK_LAST = BCNT_W'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_RST  = ~NUM_DIGITS'(1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_t;

  disp_t                 in_w;
  logic [RCNT_W-1:0]     refresh_cnt_q, refresh_cnt_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [BCNT_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  disp_t                 shadow_q, shadow_d;
  disp_t                 active_q, active_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_done_q, frame_done_d;

  logic                        ref_tc, blink_tc, frame_end, blink_off;
  logic [NUM_DIGITS-1:0][6:0]  lane_seg;

  assign in_w = {digits_in, dp_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      slot_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      pend_q        <= 1'b0;
      anode_q       <= ANODE_RST;
      seg_q         <= 7'b1111111;
      dp_n_q        <= 1'b1;
      load_ack_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      slot_q        <= slot_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      load_ack_q    <= load_ack_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Refresh and blink dividers
  always_comb begin
    ref_tc        = (refresh_cnt_q == REF_LAST);
    frame_end     = ref_tc && (slot_q == SLOT_LAST);
    refresh_cnt_d = ref_tc ? '0 : refresh_cnt_q + 1'b1;
    slot_d        = slot_q;
    if (ref_tc) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    blink_tc      = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_tc ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_tc;
  end

  // A load landing on the boundary cycle goes straight to active; otherwise it waits in shadow.
  always_comb begin
    shadow_d     = load ? in_w : shadow_q;
    active_d     = active_q;
    pend_d       = pend_q;
    load_ack_d   = 1'b0;
    frame_done_d = frame_end;
    if (frame_end) begin
      pend_d = 1'b0;
      if (load) begin
        active_d   = in_w;
        load_ack_d = 1'b1;
      end else if (pend_q) begin
        active_d   = shadow_q;
        load_ack_d = 1'b1;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    logic lz_blank;
    assign lz_blank = blank_lz && (k != 0) && (active_d.dig[NUM_DIGITS-1:k] == '0);
    seg_hex_dec u_dec (
      .nib   (active_d.dig[k]),
      .blank (lz_blank),
      .seg_n (lane_seg[k])
    );
  end

  // Everything is registered from next-state values so anode, segments and dp switch together.
  always_comb begin
    blink_off = blink_phase_d && blink_mask[slot_d];
    anode_d   = ~(NUM_DIGITS'(1) << slot_d);
    seg_d     = blink_off ? 7'b1111111 : lane_seg[slot_d];
    dp_n_d    = blink_off || !active_d.dp[slot_d];
  end

  assign anode_code = anode_q;
  assign seg_code   = seg_q;
  assign dp_n       = dp_n_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-level vector table, corner-case sequences and a
// random run, all checked every cycle against a cycle-count reference model.

module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int BD    = 64;
  localparam int FRAME = N * RD;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic           load = 1'b0;
  logic [N-1:0]   blink_mask = '0;
  logic           blank_lz = 1'b0;
  logic [N-1:0]   anode_code;
  logic [6:0]     seg_code;
  logic           dp_n, load_ack, frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .anode_code (anode_code),
    .seg_code   (seg_code),
    .dp_n       (dp_n),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int c       = 0;   // clock edges since reset release
  int ack_cnt = 0;

  // Reference state: what is on display and what is waiting for the next frame.
  logic [15:0] m_act = '0, m_pval = '0;
  logic [3:0]  m_adp = '0, m_pdp = '0;
  logic        m_pend = 1'b0;

  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t edge=%0d: got %h expected %h", name, $time, c, act, exp);
    end
  endtask

  task automatic m_reset();
    c = 0; m_act = '0; m_adp = '0; m_pval = '0; m_pdp = '0; m_pend = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_anode"}, anode_code, 4'b1110);
    chk({tag, "_seg"}, seg_code, 7'b1111111);
    chk({tag, "_dp_n"}, dp_n, 1'b1);
    chk({tag, "_ack"}, load_ack, 1'b0);
    chk({tag, "_fd"}, frame_done, 1'b0);
  endtask

  // One clock: model the edge from the sampled inputs, then compare every output.
  task automatic tick();
    logic        ld, blz, ph, off, lzb, eack, efd;
    logic [15:0] dg;
    logic [3:0]  dpv, msk, ean;
    logic [6:0]  eseg;
    int          s;
    ld = load; dg = digits_in; dpv = dp_in; msk = blink_mask; blz = blank_lz;
    @(posedge clk);
    c++;
    if (ld) begin m_pend = 1'b1; m_pval = dg; m_pdp = dpv; end
    efd  = (c % FRAME) == 0;
    eack = 1'b0;
    if (efd && m_pend) begin m_act = m_pval; m_adp = m_pdp; m_pend = 1'b0; eack = 1'b1; end
    s    = (c / RD) % N;
    ph   = ((c / BD) % 2) == 1;
    off  = ph && msk[s];
    lzb  = blz && (s != 0) && ((m_act >> (4 * s)) == 16'h0);
    eseg = (off || lzb) ? 7'b1111111 : hex7(m_act[4*s +: 4]);
    ean  = ~(4'b0001 << s);
    #1;
    if (load_ack === 1'b1) ack_cnt++;
    chk("anode", anode_code, ean);
    chk("seg", seg_code, eseg);
    chk("dp_n", dp_n, off || !m_adp[s]);
    chk("load_ack", load_ack, eack);
    chk("frame_done", frame_done, efd);
  endtask

  task automatic run_to_slot(input int k);
    for (int n = 0; n < 2 * FRAME && (c % FRAME) != k * RD; n++) tick();
  endtask

  task automatic run_until_mod(input int m, input int r);
    for (int n = 0; n < m && (c % m) != r; n++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int a0;
    tbl[0] = '{dig:16'h1234, dp:4'b0000, blz:1'b0, dpn:4'b1111,
               seg:{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{dig:16'h0070, dp:4'b0000, blz:1'b1, dpn:4'b1111,
               seg:{7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}};
    tbl[2] = '{dig:16'h0000, dp:4'b0100, blz:1'b1, dpn:4'b1011,
               seg:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
    tbl[3] = '{dig:16'h00F0, dp:4'b0000, blz:1'b0, dpn:4'b1111,
               seg:{7'b1000000, 7'b1000000, 7'b0001110, 7'b1000000}};
    tbl[4] = '{dig:16'hABCD, dp:4'b1010, blz:1'b1, dpn:4'b0101,
               seg:{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
    tbl[5] = '{dig:16'h0100, dp:4'b0001, blz:1'b1, dpn:4'b1110,
               seg:{7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000}};
    tbl[6] = '{dig:16'h8E69, dp:4'b1111, blz:1'b1, dpn:4'b0000,
               seg:{7'b0000000, 7'b0000110, 7'b0000010, 7'b0010000}};
    tbl[7] = '{dig:16'h5007, dp:4'b0000, blz:1'b1, dpn:4'b1111,
               seg:{7'b0010010, 7'b1000000, 7'b1000000, 7'b1111000}};

    // Reset asserted before any clock edge
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Single load, first boundary, full scan
    do_load(16'h1234, 4'b0000);
    run_to_slot(0);
    chk("t1_ack", load_ack, 1'b1);
    chk("t1_fd", frame_done, 1'b1);
    chk("t1_an0", anode_code, 4'b1110);
    chk("t1_seg0", seg_code, 7'b0011001);
    run_to_slot(1); chk("t1_an1", anode_code, 4'b1101); chk("t1_seg1", seg_code, 7'b0110000);
    run_to_slot(2); chk("t1_an2", anode_code, 4'b1011); chk("t1_seg2", seg_code, 7'b0100100);
    run_to_slot(3); chk("t1_an3", anode_code, 4'b0111); chk("t1_seg3", seg_code, 7'b1111001);
    run_to_slot(0);
    chk("t1_acks", ack_cnt, 1);

    // Tear-free: two loads mid-frame, last one wins at the next boundary
    a0 = ack_cnt;
    run_to_slot(1);
    do_load(16'hAAAA, 4'b0000);
    run_to_slot(2); chk("t2_hold2", seg_code, 7'b0100100);
    do_load(16'h5555, 4'b0000);
    run_to_slot(3); chk("t2_hold3", seg_code, 7'b1111001);
    run_to_slot(0); chk("t2_ack", load_ack, 1'b1);
    for (int k = 0; k < N; k++) begin
      run_to_slot(k);
      chk("t2_five", seg_code, 7'b0010010);
    end
    run_to_slot(0);
    chk("t2_acks", ack_cnt - a0, 1);

    // Load exactly on the boundary cycle bypasses the shadow
    a0 = ack_cnt;
    run_until_mod(FRAME, FRAME - 1);
    do_load(16'h00F0, 4'b0000);
    chk("t3_ack", load_ack, 1'b1);
    chk("t3_seg0", seg_code, 7'b1000000);
    run_to_slot(1); chk("t3_seg1", seg_code, 7'b0001110);
    run_to_slot(0);
    chk("t3_no_pend", load_ack, 1'b0);
    chk("t3_acks", ack_cnt - a0, 1);

    // Frame-level decode / blanking / dp table
    for (int i = 0; i < 8; i++) begin
      blank_lz = tbl[i].blz;
      do_load(tbl[i].dig, tbl[i].dp);
      run_to_slot(0);
      for (int k = 0; k < N; k++) begin
        run_to_slot(k);
        chk($sformatf("tbl%0d_seg%0d", i, k), seg_code, tbl[i].seg[k]);
        chk($sformatf("tbl%0d_dp%0d", i, k), dp_n, tbl[i].dpn[k]);
      end
    end
    blank_lz = 1'b0;

    // Blink on digits 0 and 1 only
    do_load(16'h1234, 4'b0001);
    run_to_slot(0);
    blink_mask = 4'b0011;
    run_until_mod(2 * BD, BD);
    chk("t5_off_seg0", seg_code, 7'b1111111);
    chk("t5_off_dp0", dp_n, 1'b1);
    run_to_slot(1); chk("t5_off_seg1", seg_code, 7'b1111111);
    run_to_slot(2); chk("t5_steady2", seg_code, 7'b0100100);
    run_to_slot(3); chk("t5_steady3", seg_code, 7'b1111001);
    run_until_mod(2 * BD, 0);
    chk("t5_on_seg0", seg_code, 7'b0011001);
    chk("t5_on_dp0", dp_n, 1'b0);
    run_to_slot(1); chk("t5_on_seg1", seg_code, 7'b0110000);
    run_to_slot(2); chk("t5_on_seg2", seg_code, 7'b0100100);
    blink_mask = '0;

    // Async reset mid-slot with a load pending
    run_to_slot(1);
    do_load(16'h9999, 4'b1111);
    tick();
    #2 rst = 1'b1;
    #1 chk_reset_vals("t6");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    a0 = ack_cnt;
    tick();
    chk("t6_an0", anode_code, 4'b1110);
    chk("t6_seg0", seg_code, 7'b1000000);
    for (int n = 0; n < 3 * FRAME; n++) tick();
    chk("t6_no_ack", ack_cnt - a0, 0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int j = 0; j < N; j++)
        digits_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      dp_in = 4'($urandom_range(0, 15));
      load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      tick();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
